// File: rtl/serdes_cipher_receiver.sv
// Serial cipher receiver: MSB-first byte assembly, key-byte removal, and an
// output FIFO with valid/ready handshake plus sticky frame/overflow flags.
module serdes_cipher_receiver #(
  parameter logic [7:0] KEY_BYTE   = 8'h34,
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ser_bit,
  input  logic                          ser_valid,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    byte_count,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clr_err
);
  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RECV    = 1'b1;

  logic [0:0]    state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    idle_cnt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic       push, pop, full, push_ok, timeout;
  logic [7:0] push_data;

  assign push      = (state == RECV) && ser_valid && (bit_cnt == 4'd7);
  assign push_data = {shift[6:0], ser_bit} ^ KEY_BYTE;
  // idle_cnt counts low edges already seen; this edge is the TIMEOUT-th
  assign timeout   = (state == RECV) && !ser_valid && (idle_cnt == TO_LAST);
  assign full      = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (ser_valid) begin
          shift   <= {7'd0, ser_bit};
          bit_cnt <= 4'd1;
          state   <= RECV;
        end
        default: if (ser_valid) begin
          shift    <= {shift[6:0], ser_bit};
          idle_cnt <= '0;
          if (bit_cnt == 4'd7) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else if (timeout) begin
          shift    <= '0;
          bit_cnt  <= '0;
          idle_cnt <= '0;
          state    <= IDLE;
        end else begin
          idle_cnt <= idle_cnt + 8'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      byte_count <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
        byte_count  <= byte_count + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (!push_ok && pop) fifo_level <= fifo_level - 1'b1;
      // a new event on the clearing edge keeps the flag set
      frame_err <= (frame_err && !clr_err) || timeout;
      overflow  <= (overflow && !clr_err) || (push && full && !pop);
    end
  end
endmodule

// File: doc/serdes_cipher_receiver.md
# serdes_cipher_receiver

Receive-side stage that consumes the serial ciphertext stream from the encryptor core's cipher output path. It reassembles MSB-first bits into bytes, removes the key byte to recover A^B, and buffers the results in a small FIFO with a valid/ready output handshake. It also flags incomplete frames (timeout) and FIFO overflow.

## Interface
- KEY_BYTE, 8'h34, key byte XORed onto each received byte; matches key[7:0] of the core key.
- FIFO_DEPTH, 4, output FIFO entries; power of two, 2..16.
- TIMEOUT, 15, idle cycles tolerated mid-byte before the partial byte is discarded; 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- ser_bit  in  1  serial cipher bit, MSB of each byte first.
- ser_valid  in  1  ser_bit is sampled on this edge.
- out_data  out  8  decrypted byte at the FIFO head.
- out_valid  out  1  FIFO is not empty.
- out_ready  in  1  consumer accepts the head; a pop occurs when out_valid and out_ready are both high.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- byte_count  out  8  bytes written into the FIFO since reset; wraps 255->0.
- frame_err  out  1  sticky; a partial byte was discarded on timeout.
- overflow  out  1  sticky; a completed byte was dropped because the FIFO was full.
- clr_err  in  1  clears frame_err and overflow.

## Operation
- Reset, with rst high at an edge: state=IDLE, bit_cnt=0, shift=0, idle_cnt=0, FIFO empty, out_valid=0, out_data=0, fifo_level=0, byte_count=0, frame_err=0, overflow=0. Reset overrides all other inputs, including mid-byte and with the FIFO full.
- States:
  - IDLE: no partial byte is held. A ser_valid edge shifts in ser_bit, sets bit_cnt=1, and moves to RECV.
  - RECV: 1..7 bits are held.
    - Each ser_valid edge gives shift={shift[6:0],ser_bit}, bit_cnt+1, idle_cnt=0.
    - An edge with ser_valid low increments idle_cnt.
    - Completion: on the edge sampling the 8th bit, the assembled byte {shift[6:0],ser_bit}^KEY_BYTE is offered to the FIFO write, and the block returns to IDLE with bit_cnt=0.
    - Timeout: if idle_cnt reaches TIMEOUT at an edge, the partial byte is discarded, frame_err is set to 1, and the block returns to IDLE with bit_cnt=0 and idle_cnt=0.
- FIFO: circular buffer with wrapping read and write pointers. out_data always shows the head entry and is 0 when the FIFO is empty.
  - Push when not full: the entry is written, fifo_level+1, byte_count+1.
  - Push when full with no pop on the same edge: the byte is dropped, overflow=1, byte_count is unchanged.
  - Push when full with a pop on the same edge: both are performed, fifo_level is unchanged, byte_count+1, overflow is not set.
  - Push and pop on the same edge when not full: fifo_level is unchanged.
  - Pop when empty cannot occur, because out_valid=0.
- Sticky flags:
  - clr_err clears both flags at the edge.
  - If a new error event occurs on the same edge as clr_err, the set wins.
- Data rule: all arithmetic is 8-bit unsigned. There is no filtering or majority voting in this block.

## Timing
- Latency: when the 8th bit is sampled at edge N and the FIFO was empty, out_valid=1 and out_data is valid from edge N until after edge N+1 at the earliest.
- Throughput: one byte per 8 valid-bit edges. Back-to-back bytes are accepted with no gap cycle.
- The FIFO is not first-word-fall-through beyond registered storage. out_data and out_valid are registered or derived from registered pointers, with no combinational path from ser_bit.
- out_ready may change every cycle. The same head is presented until it is popped.
- byte_count, fifo_level and the flags update on the same edge as the event that causes them.

## Test plan
- Reset, then the bits of 0xA5 (1,0,1,0,0,1,0,1) with ser_valid held high for 8 edges and out_ready=0: out_valid rises after the 8th edge, out_data=0x91, fifo_level=1, byte_count=1.
- Bytes 0x00, 0xFF, 0x34, 0x12 sent back-to-back with out_ready=1: out_data sequence is 0x34, 0xCB, 0x00, 0x26 in order, fifo_level never exceeds 1, no flags are set.
- Five bytes sent with out_ready=0 and FIFO_DEPTH=4: fifo_level=4, overflow=1, byte_count=4, and the first 4 bytes drain in order once out_ready=1. Repeat with out_ready pulsed on the 5th push edge: overflow=0 and byte_count=5.
- 3 bits sent, then ser_valid held low for 15 edges: frame_err=1, bit_cnt is back to 0, and a following full byte 0xA5 decodes correctly to 0x91. clr_err then clears frame_err. clr_err asserted on the same edge as a timeout leaves frame_err=1.
- rst asserted after 5 bits of a byte with 2 bytes queued: all outputs return to reset values. A new byte 0x3C afterwards yields 0x08.
- 256 bytes pushed with out_ready=1: byte_count wraps to 0 and no flags are set.
